// File: rtl/arith_pkg.sv
// Shared definitions for the RV32IM execute unit: funct3/funct7 encodings,
// internal op enum, {funct7,funct3} decode and the sequencing FSM states.
package arith_pkg;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    // M-ops occupy 16..23 so op[4:3]==2'b10 identifies them cheaply.
    typedef enum logic [4:0] {
        ALU_ADD     = 5'd0,
        ALU_SUB     = 5'd1,
        ALU_SLL     = 5'd2,
        ALU_SLT     = 5'd3,
        ALU_SLTU    = 5'd4,
        ALU_XOR     = 5'd5,
        ALU_SRL     = 5'd6,
        ALU_SRA     = 5'd7,
        ALU_OR      = 5'd8,
        ALU_AND     = 5'd9,
        ALU_MUL     = 5'd16,
        ALU_MULH    = 5'd17,
        ALU_MULHSU  = 5'd18,
        ALU_MULHU   = 5'd19,
        ALU_DIV     = 5'd20,
        ALU_DIVU    = 5'd21,
        ALU_REM     = 5'd22,
        ALU_REMU    = 5'd23,
        ALU_ILLEGAL = 5'd31
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_ITER  = 2'd2,
        S_FIXUP = 2'd3
    } state_e;

    function automatic op_e decode_op(input logic [6:0] f7, input logic [2:0] f3);
        op_e op;
        op = ALU_ILLEGAL;
        case (f7)
            F7_BASE: begin
                case (f3)
                    F3_ADD_SUB: op = ALU_ADD;
                    F3_SLL:     op = ALU_SLL;
                    F3_SLT:     op = ALU_SLT;
                    F3_SLTU:    op = ALU_SLTU;
                    F3_XOR:     op = ALU_XOR;
                    F3_SR:      op = ALU_SRL;
                    F3_OR:      op = ALU_OR;
                    default:    op = ALU_AND;
                endcase
            end
            F7_ALT: begin
                if (f3 == F3_ADD_SUB) op = ALU_SUB;
                else if (f3 == F3_SR) op = ALU_SRA;
            end
            F7_MULDIV: begin
                case (f3)
                    3'd0:    op = ALU_MUL;
                    3'd1:    op = ALU_MULH;
                    3'd2:    op = ALU_MULHSU;
                    3'd3:    op = ALU_MULHU;
                    3'd4:    op = ALU_DIV;
                    3'd5:    op = ALU_DIVU;
                    3'd6:    op = ALU_REM;
                    default: op = ALU_REMU;
                endcase
            end
            default: op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

    function automatic logic is_mop(input op_e op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine working on unsigned magnitudes.
//  Multiply: shift-add, result {hi,lo} = a*b.
//  Divide:   restoring, result hi = a % b, lo = a / b (b==0 gives lo=all ones).
// Ports: start loads operands (one cycle), busy high for DATA_WIDTH steps,
//  done high during the final step so the caller can move on at the same edge.
module muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] b_r;
    logic                  div_r;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH:0]   sum, sh;
    logic [DATA_WIDTH-1:0] diff, step_hi, step_lo;
    logic                  ge;

    always_comb begin
        // Multiply: conditionally add into the high half, then shift the pair right.
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
        // Divide: shift next dividend bit into the partial remainder, try subtract.
        sh   = {hi, lo[DATA_WIDTH-1]};
        ge   = (sh >= {1'b0, b_r});
        diff = sh[DATA_WIDTH-1:0] - b_r;   // only used when ge, so fits in DATA_WIDTH
        if (div_r) begin
            step_hi = ge ? diff : sh[DATA_WIDTH-1:0];
            step_lo = {lo[DATA_WIDTH-2:0], ge};
        end else begin
            step_hi = sum[DATA_WIDTH:1];
            step_lo = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            hi    <= '0;
            lo    <= a;
            b_r   <= b;
            div_r <= is_div;
            cnt   <= CNT_W'(DATA_WIDTH - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_arithmetic.sv
// Registered RV32I reg-reg ALU plus RV32M MUL/DIV/REM execute unit.
// Ports:
//  clk, rst_n          clock, async active-low reset
//  in_valid/in_ready   operand handshake (lhs, rhs, funct3, funct7)
//  out_valid/out_ready result handshake (result, illegal)
// Single-cycle ops land in the output register the cycle after accept; M-ops
// go SETUP -> ITER (DATA_WIDTH steps) -> FIXUP and land DATA_WIDTH+2 cycles later.
module muldiv_arithmetic
    import arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int DW      = DATA_WIDTH;

    state_e          state_q, state_d;
    op_e             in_op, op_q;
    logic [DW-1:0]   a_q, b_q;
    logic            accept;
    logic [DW-1:0]   alu_res;
    logic [SHAMT_W-1:0] shamt;

    logic            sa, sb, neg_a, neg_b, is_div_q;
    logic [DW-1:0]   mag_a, mag_b;
    logic            eng_start, eng_busy, eng_done;
    logic [DW-1:0]   eng_hi, eng_lo;
    logic [2*DW-1:0] prod, prod_s;
    logic [DW-1:0]   quot_s, rem_s, fix_res;

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign in_op    = decode_op(funct7, funct3);
    assign shamt    = rhs[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (in_op)
            ALU_ADD:  alu_res = lhs + rhs;
            ALU_SUB:  alu_res = lhs - rhs;
            ALU_SLL:  alu_res = lhs << shamt;
            ALU_SLT:  alu_res[0] = ($signed(lhs) < $signed(rhs));
            ALU_SLTU: alu_res[0] = (lhs < rhs);
            ALU_XOR:  alu_res = lhs ^ rhs;
            ALU_SRL:  alu_res = lhs >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(lhs) >>> shamt);
            ALU_OR:   alu_res = lhs | rhs;
            ALU_AND:  alu_res = lhs & rhs;
            default:  alu_res = '0;
        endcase
    end

    // Operand signedness for the captured M-op.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (op_q)
            ALU_MULH:         begin sa = 1'b1; sb = 1'b1; end
            ALU_MULHSU:       sa = 1'b1;
            ALU_DIV, ALU_REM: begin sa = 1'b1; sb = 1'b1; end
            default:          ;
        endcase
    end

    assign neg_a    = sa && a_q[DW-1];
    assign neg_b    = sb && b_q[DW-1];
    assign mag_a    = neg_a ? -a_q : a_q;
    assign mag_b    = neg_b ? -b_q : b_q;
    assign is_div_q = (op_q == ALU_DIV) || (op_q == ALU_DIVU) ||
                      (op_q == ALU_REM) || (op_q == ALU_REMU);

    muldiv_iter #(.DATA_WIDTH(DW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start),
        .is_div (is_div_q),
        .a      (mag_a),
        .b      (mag_b),
        .busy   (eng_busy),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    // Sign fixup. Negating min_int wraps back to min_int, which yields the
    // required DIV(min_int,-1) result without a special case.
    always_comb begin
        prod   = {eng_hi, eng_lo};
        prod_s = (neg_a ^ neg_b) ? -prod : prod;
        quot_s = (neg_a ^ neg_b) ? -eng_lo : eng_lo;
        rem_s  = neg_a ? -eng_hi : eng_hi;   // remainder follows dividend sign
        case (op_q)
            ALU_MUL:                         fix_res = prod_s[DW-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod_s[2*DW-1:DW];
            ALU_DIV, ALU_DIVU:               fix_res = (b_q == '0) ? '1  : quot_s;
            ALU_REM, ALU_REMU:               fix_res = (b_q == '0) ? a_q : rem_s;
            default:                         fix_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        case (state_q)
            S_IDLE:  if (accept && is_mop(in_op)) state_d = S_SETUP;
            S_SETUP: begin
                eng_start = 1'b1;
                state_d   = S_ITER;
            end
            S_ITER: begin
                if (eng_done)      state_d = S_FIXUP;
                else if (!eng_busy) state_d = S_IDLE;  // engine lost its op: never hang
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= in_op;
                a_q  <= lhs;
                b_q  <= rhs;
            end
        end
    end

    // Output register: holds until consumed; a same-cycle load wins over the fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && !is_mop(in_op)) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                illegal   <= (in_op == ALU_ILLEGAL);
            end else if (state_q == S_FIXUP) begin
                out_valid <= 1'b1;
                result    <= fix_res;
                illegal   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_arithmetic.sv
module tb_muldiv_arithmetic;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] lhs = '0, rhs = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    muldiv_arithmetic #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Present a bundle at a falling edge, wait (bounded) for in_ready, and
    // return 1 ns after the accepting rising edge with in_valid dropped.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [6:0] f7);
        int n;
        n = 0;
        @(negedge clk);
        lhs = a; rhs = b; funct3 = f3; funct7 = f7; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, illegal, in_ready} !== 3'b000 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b illegal=%b in_ready=%b result=%h required 0 0 0 00000000",
                     out_valid, illegal, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_alu;
        logic [31:0] va [11], vb [11], ve [11];
        logic [2:0]  vf3 [11];
        logic [6:0]  vf7 [11];
        va = '{32'd7, 32'd0, 32'h8000_0000, 32'd1, 32'd1, 32'd1, 32'hF0F0_F0F0,
               32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
        vb = '{32'hFFFF_FFFD, 32'd1, 32'd4, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFF00_FF00, 32'h24, 32'h0F0F_0000, 32'hFF00_FF00, 32'd1};
        vf3 = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        vf7 = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        ve = '{32'd4, 32'hFFFF_FFFF, 32'hF800_0000, 32'd2, 32'd1, 32'd0, 32'h0FF0_0FF0,
               32'h0800_0000, 32'hFFFF_F0F0, 32'hF000_F000, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(va[i], vb[i], vf3[i], vf7[i]);
            checks++;
            if (out_valid !== 1'b1 || illegal !== 1'b0 || result !== ve[i]) begin
                errors++;
                $display("FAIL alu_%0d out_valid=%b illegal=%b result=%h required 1 0 %h",
                         i, out_valid, illegal, result, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_r [3];
        exp_r = '{32'd3, 32'd7, 32'h0000_0010};
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            case (i)
                0:       begin lhs = 32'd1;  rhs = 32'd2;  funct3 = 3'd0; funct7 = 7'h00; end
                1:       begin lhs = 32'd10; rhs = 32'd3;  funct3 = 3'd0; funct7 = 7'h20; end
                default: begin lhs = 32'd1;  rhs = 32'd4;  funct3 = 3'd1; funct7 = 7'h00; end
            endcase
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r[i]) begin
                errors++;
                $display("FAIL b2b_result_%0d out_valid=%b result=%h required 1 %h",
                         i, out_valid, result, exp_r[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mop;
        logic [31:0] va [10], vb [10], ve [10];
        logic [2:0]  vf3 [10];
        int lat;
        va = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'd7,
               32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        vb = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF, 32'd0,
               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
        vf3 = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6, 3'd4};
        ve = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h2345_6780, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
               32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(va[i], vb[i], vf3[i], 7'h01);
            // Scramble inputs after accept; the captured operands must be used.
            lhs = 32'hDEAD_BEEF; rhs = 32'h0; funct3 = 3'd0; funct7 = 7'h00;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != 34) begin
                errors++;
                $display("FAIL mop_latency_%0d cycles=%0d required 34", i, lat);
            end
            checks++;
            if (result !== ve[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL mop_result_%0d result=%h illegal=%b required %h 0",
                         i, result, illegal, ve[i]);
            end
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send(32'd3, 32'd4, 3'd0, 7'h40);
        checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL illegal_f7_40 out_valid=%b illegal=%b result=%h required 1 1 00000000",
                     out_valid, illegal, result);
        end
        send(32'd3, 32'd4, 3'd4, 7'h20);
        checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL illegal_xor_20 out_valid=%b illegal=%b result=%h required 1 1 00000000",
                     out_valid, illegal, result);
        end
        send(32'd3, 32'd5, 3'd4, 7'h00);
        checks++;
        if (illegal !== 1'b0 || result !== 32'd6) begin
            errors++;
            $display("FAIL illegal_clear illegal=%b result=%h required 0 00000006", illegal, result);
        end
    endtask

    task automatic test_hold;
        out_ready = 1'b1;
        send(32'd5, 32'd6, 3'd0, 7'h00);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd11 || illegal !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d out_valid=%b result=%h illegal=%b in_ready=%b required 1 0000000b 0 0",
                         i, out_valid, result, illegal, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_iter;
        logic seen;
        out_ready = 1'b1;
        send(32'd100, 32'd7, 3'd4, 7'h01);
        // Accept edge, SETUP edge, then steps 1..10.
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset out_valid=%b in_ready=%b result=%h required 0 0 00000000",
                     out_valid, in_ready, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ghost out_valid seen=%b required 0", seen);
        end
        send(32'd20, 32'd22, 3'd0, 7'h00);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd42) begin
            errors++;
            $display("FAIL post_reset_add out_valid=%b result=%h required 1 0000002a", out_valid, result);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_mop();
        test_illegal();
        test_hold();
        test_reset_mid_iter();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
